// File: rtl/sum_accumulator.sv
// sum_accumulator: accumulates groups of COUNT unsigned operands (or a shorter flushed group) into one registered result
// Ports:
//   IN_clk, IN_rstn          clock, asynchronous active-low reset
//   IN_valid/IN_ready        operand handshake, IN_data is the WIDTH-bit operand
//   IN_flush                 closes a partial group (only while accumulating)
//   OUT_valid/OUT_ready      result handshake
//   OUT_sum, OUT_cnt         group total (ACC_W bits) and operand count of the group
//   OUT_ovf                  only with SUM_ACCUMULATOR_NARROW_EN: total exceeded 2^WIDTH-1, OUT_sum clamped
module sum_accumulator #(
  parameter int WIDTH = 2,
  parameter int COUNT = 4,
  localparam int ACC_W = WIDTH + $clog2(COUNT),
  localparam int CNT_W = $clog2(COUNT + 1)
) (
  input  logic             IN_clk,
  input  logic             IN_rstn,
  input  logic             IN_valid,
  input  logic [WIDTH-1:0] IN_data,
  input  logic             IN_flush,
  output logic             IN_ready,
  output logic             OUT_valid,
  input  logic             OUT_ready,
  output logic [ACC_W-1:0] OUT_sum,
  output logic [CNT_W-1:0] OUT_cnt
`ifdef SUM_ACCUMULATOR_NARROW_EN
  ,
  output logic             OUT_ovf
`endif
);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, sum_q, sum_d, data_ext, acc_nxt, total;
  logic [CNT_W-1:0] cnt_q, cnt_d, ocnt_q, ocnt_d, cnt_nxt, tcnt;
  logic accept, emit, close;
`ifdef SUM_ACCUMULATOR_NARROW_EN
  logic ovf_q, ovf_d, ovf;
`endif
  always_comb begin
    data_ext = ACC_W'(IN_data);
    IN_ready = state_q == ACCUM || OUT_ready;
    OUT_valid = state_q == HOLD;
    accept = IN_valid && IN_ready;
    emit = OUT_valid && OUT_ready;
    acc_nxt = acc_q + data_ext;
    cnt_nxt = cnt_q + 1'b1;
    // totals including an operand accepted in this same cycle
    total = accept ? acc_nxt : acc_q;
    tcnt = accept ? cnt_nxt : cnt_q;
    // a flush on an empty group with nothing arriving is ignored
    close = state_q == ACCUM && ((accept && cnt_nxt == CNT_W'(COUNT)) || (IN_flush && (cnt_q != '0 || accept)));
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (state_q == ACCUM) begin
      acc_d = close ? '0 : total;
      cnt_d = close ? '0 : tcnt;
      state_d = close ? HOLD : ACCUM;
    end else if (emit) begin
      // pass-through accept in the emit cycle starts the next group
      acc_d = accept ? data_ext : '0;
      cnt_d = accept ? CNT_W'(1) : '0;
      state_d = ACCUM;
    end
    ocnt_d = close ? tcnt : ocnt_q;
`ifdef SUM_ACCUMULATOR_NARROW_EN
    ovf = |total[ACC_W-1:WIDTH];
    sum_d = close ? (ovf ? ACC_W'({WIDTH{1'b1}}) : total) : sum_q;
    ovf_d = close ? ovf : ovf_q;
`else
    sum_d = close ? total : sum_q;
`endif
  end
  always_ff @(posedge IN_clk or negedge IN_rstn) begin
    if (!IN_rstn) begin
      state_q <= ACCUM;
      acc_q <= '0;
      cnt_q <= '0;
      sum_q <= '0;
      ocnt_q <= '0;
`ifdef SUM_ACCUMULATOR_NARROW_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      ocnt_q <= ocnt_d;
`ifdef SUM_ACCUMULATOR_NARROW_EN
      ovf_q <= ovf_d;
`endif
    end
  end
  assign OUT_sum = sum_q;
  assign OUT_cnt = ocnt_q;
`ifdef SUM_ACCUMULATOR_NARROW_EN
  assign OUT_ovf = ovf_q;
`endif
endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
- Downstream consumer stage for a combinational summing stage. It takes a stream of WIDTH-bit sums through a valid/ready handshake and accumulates groups of COUNT operands, or a shorter partial group on flush.
- Each group total is presented as one registered result with its own valid/ready handshake.
- Sits between the combinational adder and any narrower registered sink.

Parameters:
- WIDTH, 2, bit width of each incoming operand (matches upstream sum width).
- COUNT, 4, operands per complete group; legal range 2..256.
- ACC_W (localparam), WIDTH+$clog2(COUNT), accumulator/result width; never overflows for a full group.
- CNT_W (localparam), $clog2(COUNT+1), width of operand-count output.

Ports:
- IN_clk  input  1  clock; all state updates on rising edge.
- IN_rstn  input  1  reset, asynchronous assert, active-low.
- IN_valid  input  1  upstream operand valid.
- IN_data  input  WIDTH  operand, unsigned.
- IN_flush  input  1  close the current partial group; sampled only in ACCUM.
- IN_ready  output  1  stage can accept an operand this cycle.
- OUT_valid  output  1  result valid.
- OUT_ready  input  1  downstream accepts the result.
- OUT_sum  output  ACC_W  group total, unsigned, zero-extended operands.
- OUT_cnt  output  CNT_W  number of operands in the presented group (1..COUNT).

Behaviour:
- Reset values (while IN_rstn=0): state=ACCUM, acc=0, cnt=0, OUT_valid=0, OUT_sum=0, OUT_cnt=0. Reset mid-group or mid-hold discards all data; no result is emitted.
- Accept = IN_valid & IN_ready. Emit = OUT_valid & OUT_ready.
- State ACCUM:
  - IN_ready=1, OUT_valid=0.
  - On accept: acc<=acc+IN_data, cnt<=cnt+1.
  - If the accept makes cnt reach COUNT: OUT_sum<=acc+IN_data, OUT_cnt<=COUNT, acc<=0, cnt<=0, go to HOLD.
  - IN_flush=1 with (cnt>0 or accept): close the group. Any operand accepted in the same cycle is included. OUT_sum and OUT_cnt load the resulting totals, then go to HOLD.
  - IN_flush=1 with cnt=0 and no accept: ignored, no empty result.
- State HOLD:
  - OUT_valid=1. OUT_sum and OUT_cnt stay stable until Emit.
  - IN_ready=OUT_ready, so a pass-through accept is possible only in the Emit cycle.
  - Emit without accept: go to ACCUM with acc=0, cnt=0.
  - Emit with accept: go to ACCUM with acc=IN_data, cnt=1. If COUNT... not applicable, since COUNT>=2 so one operand never completes a group.
  - IN_flush is ignored in HOLD.
- Latency: result is visible (OUT_valid=1) the cycle after the completing accept or flush.
- Throughput: one operand per cycle sustained while OUT_ready=1. Exactly one dead cycle per group, where the output presents the result. It overlaps with the next group's first accept when OUT_ready=1.
- Arithmetic: operands are zero-extended to ACC_W; the sum is modulo 2^ACC_W, which is unreachable for a full group.
- Protocol: IN_data is sampled only on accept. OUT_valid never drops without Emit.

Optional Feature:
- Macro: SUM_ACCUMULATOR_NARROW_EN.
- When defined:
  - Adds output OUT_ovf (1 bit, reset 0, stable with OUT_sum).
  - OUT_ovf is set when the exact group total exceeds 2^WIDTH-1.
  - OUT_sum is then clamped to 2^WIDTH-1, zero-extended to ACC_W, so a WIDTH-bit sink can take it directly.
- When undefined: no OUT_ovf port; OUT_sum carries the full unclamped ACC_W total.

Test Plan:
- WIDTH=8, COUNT=4, OUT_ready=1; operands 10,20,30,40 on 4 consecutive cycles -> OUT_valid=1 on the next cycle with OUT_sum=100, OUT_cnt=4, held 1 cycle.
- Operands 255 x4 -> OUT_sum=1020. With SUM_ACCUMULATOR_NARROW_EN: OUT_sum=255, OUT_ovf=1.
- Operands 7,9, then IN_flush=1 with no valid -> OUT_sum=16, OUT_cnt=2. A flush with cnt=0 produces no result.
- Complete a group with OUT_ready=0 for 3 cycles -> IN_ready=0 and OUT_sum stable all 3 cycles. Then OUT_ready=1 with IN_valid=1, data=5 -> result emitted, next group starts with acc=5, cnt=1.
- Back-to-back groups of 1,2,3,4 and 5,6,7,8 with continuous valid and OUT_ready=1 -> results 10 then 26, no operand lost.
- Deassert IN_rstn after 3 accepts -> outputs 0 immediately. After release, operands 1,1,1,1 give 4, not including pre-reset data.
